// File: rtl/sphere_fetch.sv
// sphere_fetch: pulls one 4-word sphere record (pos_x, pos_y, pos_z, radius)
// out of a synchronous sphere memory and presents it to the collision stage
// with a valid/ready handshake, then acknowledges the memory controller.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   address             record index from the memory controller
//   output_enable       controller enable; fetches start only while high
//   end_of_memory       controller flag; blocks new fetches while high
//   fetch_data_ready    one-cycle pulse: current record consumed
//   mem_addr, mem_rd    word address / read strobe to the sphere memory
//   mem_rdata           read data, valid one cycle after mem_rd
//   pos_x..radius       assembled record fields
//   rec_index           address latched when the fetch started
//   record_valid        record outputs valid, held until accepted
//   record_ready        consumer accepts when record_valid is also high
module sphere_fetch #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic              output_enable,
  input  logic              end_of_memory,
  output logic              fetch_data_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pos_x,
  output logic [DATA_W-1:0] pos_y,
  output logic [DATA_W-1:0] pos_z,
  output logic [DATA_W-1:0] radius,
  output logic [31:0]       rec_index,
  output logic              record_valid,
  input  logic              record_ready
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    VALID,
    ACK,
    SETTLE
  } state_t;

  state_t state, next_state;

  // Word index while in ISSUE, cycle counter while in SETTLE.
  logic [1:0] cnt, cnt_next;

  // Record base is {base_hi, 2'b00}; upper address bits wrap away.
  logic [MEM_AW-3:0] base_hi;

  logic start;

  always_comb begin
    next_state       = state;
    cnt_next         = cnt;
    mem_rd           = 1'b0;
    mem_addr         = '0;
    record_valid     = 1'b0;
    fetch_data_ready = 1'b0;
    start            = 1'b0;
    case (state)
      IDLE: begin
        if (output_enable && !end_of_memory) begin
          start      = 1'b1;
          cnt_next   = '0;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = {base_hi, cnt};
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) next_state = DRAIN;
      end
      DRAIN: next_state = VALID;
      VALID: begin
        record_valid = 1'b1;
        if (record_ready) next_state = ACK;
      end
      ACK: begin
        fetch_data_ready = 1'b1;
        cnt_next         = '0;
        next_state       = SETTLE;
      end
      SETTLE: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base_hi   <= '0;
      rec_index <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      pos_z     <= '0;
      radius    <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (start) begin
        base_hi   <= address[MEM_AW-3:0];
        rec_index <= address;
      end
      // Read data lags its issue by one cycle: issue k captures word k-1,
      // and DRAIN captures the last word.
      if (state == ISSUE) begin
        case (cnt)
          2'd1:    pos_x <= mem_rdata;
          2'd2:    pos_y <= mem_rdata;
          2'd3:    pos_z <= mem_rdata;
          default: ;
        endcase
      end
      if (state == DRAIN) radius <= mem_rdata;
    end
  end

endmodule
